// File: rtl/prog_loader_if.sv
// prog_loader_if -- bundle between a byte-stream program source / CPU wrapper
// and the program loader.
//   load_req   : one-cycle request to start a new program load
//   in_valid   : byte-stream valid
//   in_data    : byte-stream data
//   in_ready   : loader accepts a byte this cycle
//   imem_we    : instruction-memory write strobe (one cycle per word)
//   imem_addr  : word address of the current write
//   imem_wdata : assembled 32-bit instruction word
//   start      : CPU run enable
//   busy       : loader is consuming a stream
//   err        : loader is parked in its error state
// Modports: master drives the request and the byte stream, slave is the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 6
);
    logic              load_req;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              start;
    logic              busy;
    logic              err;

    modport master (
        output load_req, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, start, busy, err
    );

    modport slave (
        input  load_req, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, start, busy, err
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- loads a program from a byte stream into instruction memory,
// then releases the CPU.
// Stream format: header byte N (word count, 1..IMEM_DEPTH), then 4*N bytes,
// little-endian per word. With LOADER_CHECKSUM_EN defined, one trailing byte
// follows that must equal the mod-256 sum of all payload bytes.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : prog_loader_if.slave (request, byte stream, imem write port,
//          start/busy/err status)
// Optional feature macro: LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | after reset, waiting for load_req
// HDR   | waiting for the word-count byte
// DATA  | collecting payload bytes, writing one word every 4 bytes
// CHK   | waiting for the checksum byte (checksum builds only)
// RUN   | program loaded, start held high
// ERR   | bad header or checksum, start held low until load_req
module prog_loader #(
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    localparam int IMEM_DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
    logic [1:0]        lane;
    logic [23:0]       shift;
    logic              accept;
    logic              hdr_bad;
    logic              word_done;
    logic              last_word;
    logic              start_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = bus.in_valid & bus.in_ready;
    assign hdr_bad   = (bus.in_data == 8'd0) || (32'(bus.in_data) > 32'(IMEM_DEPTH));
    assign word_done = accept && (state == DATA) && (lane == 2'd3);
    // Terminating on the last index (not on an incremented count) lets
    // N = IMEM_DEPTH finish without needing an extra address bit.
    assign last_word = word_done && (word_idx == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERR: begin
                if (bus.load_req) state_nxt = HDR;
            end
            HDR: begin
                if (accept) state_nxt = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = RUN;
`endif
                end
            end
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) state_nxt = (bus.in_data == csum) ? RUN : ERR;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.err      = 1'b0;
        case (state)
            HDR, DATA, CHK: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            ERR:     bus.err = 1'b1;
            default: ;
        endcase
    end

    // start comes from a flop so the CPU reset release is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= (state_nxt == RUN);
        end
    end

    assign bus.start = start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx       <= '0;
            last_idx       <= '0;
            lane           <= 2'd0;
            shift          <= 24'd0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum           <= 8'd0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
            if ((state == IDLE || state == RUN || state == ERR) && bus.load_req) begin
                word_idx <= '0;
                lane     <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if (state == HDR && accept) begin
                last_idx <= ADDR_W'(bus.in_data - 8'd1);
                word_idx <= '0;
                lane     <= 2'd0;
            end
            if (state == DATA && accept) begin
                lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum <= csum + bus.in_data;
`endif
                case (lane)
                    2'd0: shift[7:0]   <= bus.in_data;
                    2'd1: shift[15:8]  <= bus.in_data;
                    2'd2: shift[23:16] <= bus.in_data;
                    default: ;
                endcase
            end
            // Fourth byte goes straight into the write word, so the stream
            // keeps flowing during the write cycle.
            if (word_done) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= word_idx;
                bus.imem_wdata <= {bus.in_data, shift};
                word_idx       <= word_idx + 1'b1;
            end
        end
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 6, instruction-memory word-address width; IMEM_DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load_req  input  1  one-cycle request to begin a program load.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of current write.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 start  output  1  CPU run enable; 0 holds the SingleCycleCPU in reset, 1 lets it execute from PC 0.
REQ-012 busy  output  1  high while in HDR, DATA or CHK.
REQ-013 err  output  1  high while in ERR.

Function
REQ-014 The loader SHALL implement states IDLE, HDR, DATA, CHK, RUN and ERR.
REQ-015 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in HDR, DATA and CHK.
REQ-016 IDLE, RUN or ERR with load_req=1 SHALL go to HDR next cycle, with start=0 from that cycle; load_req in HDR, DATA or CHK SHALL be ignored.
REQ-017 In HDR, the accepted byte SHALL be word count N; N=0 or N>IMEM_DEPTH -> ERR, otherwise -> DATA with word index 0 and byte lane 0.
REQ-018 In DATA, bytes SHALL be little-endian: byte k of a word lands in bits [8k+7:8k].
REQ-019 The cycle after the 4th byte of a word is accepted: imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word; word index then increments.
REQ-020 Byte acceptance SHALL continue without a bubble during the write cycle (throughput one byte per cycle).
REQ-021 After word N-1 is written, the next state SHALL be CHK if LOADER_CHECKSUM_EN is defined, otherwise RUN.
REQ-022 In RUN, start SHALL be a registered 1 and remain 1 until load_req or rst.
REQ-023 imem_addr SHALL never exceed N-1; N=IMEM_DEPTH SHALL write addresses 0..IMEM_DEPTH-1 without wrap.
REQ-024 ERR SHALL hold start=0 and in_ready=0 until load_req or rst.
REQ-025 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, start=0, in_ready=0, imem_we=0, busy=0, err=0, imem_addr=0, imem_wdata=0, word index 0, byte lane 0, checksum 0.
REQ-027 rst asserted mid-load SHALL abandon the load with no further imem_we; memory already written is not cleared.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: an 8-bit running sum (mod 256) of all DATA bytes SHALL be kept; in CHK one byte is accepted; match -> RUN, mismatch -> ERR.
REQ-029 Macro LOADER_CHECKSUM_EN undefined: no checksum logic, CHK unreachable, stream is header plus 4N bytes only.

Verification
REQ-030 Load N=2, bytes 13 00 50 00 / 93 02 A0 00 -> imem_we at addr 0 data 0x00500013, addr 1 data 0x00A00293, then start=1.
REQ-031 Header N=0, then separately N=IMEM_DEPTH+1 -> err=1, start=0, no imem_we.
REQ-032 Checksum enabled, N=1, bytes 01 02 03 04, check byte 0x0A -> RUN; check byte 0x0B -> ERR.
REQ-033 in_valid toggled randomly during N=3 load -> exactly 3 writes, correct words, no extra or dropped bytes.
REQ-034 rst asserted after 6 of 8 payload bytes -> immediate IDLE, start=0, only addr 0 written; a fresh load then completes normally.
REQ-035 load_req while in RUN -> start=0 the next cycle, busy=1, new program overwrites from addr 0.
